des_tdm_cipher_serializer: RTL and testbench
============================================

Name: des_tdm_cipher_serializer

Overview:
- Downstream neighbour of the DES pipeline top.
- Tracks which plaintext launches are valid through the 16-round registered pipeline.
- Captures each matching 64-bit CIPHER_TEXT into a small FIFO.
- Streams each captured block out in narrow slices, only during this block's own time slot on a shared time-division-multiplexed output bus, so ciphertext never appears on the bus outside the assigned slot.

Parameters:
- LATENCY, 16: cycles from an IN_VALID launch to the matching CIPHER_TEXT at the pipeline output.
- SLICE_W, 16: output slice width; must divide 64.
- NUM_SLOTS, 4: slots per TDM frame.
- OWN_SLOT, 0: slot index owned by this block, range 0..NUM_SLOTS-1.
- FIFO_DEPTH, 4: captured-block FIFO depth; must be a power of 2.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: asynchronous, active-high reset.
- IN_VALID, input, 1: a valid plaintext enters the DES pipeline this cycle.
- CIPHER_TEXT, input, [64:1]: DES pipeline output.
- SLOT_SYNC, input, 1: the current cycle is phase 0 of a TDM frame.
- OUT_DATA, output, [SLICE_W:1]: slice output; all-zero when OUT_VALID=0.
- OUT_VALID, output, 1: OUT_DATA carries a slice.
- OUT_LAST, output, 1: final slice of a block.
- FIFO_COUNT, output, [log2(FIFO_DEPTH)+1:1]: blocks currently held.
- OVERFLOW, output, 1: sticky; set when a block is dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears all outputs to 0: OUT_DATA, OUT_VALID, OUT_LAST, FIFO_COUNT, OVERFLOW.
  - Clears the valid delay line, FIFO pointers, phase counter, beat counter and shift register.
  - In-flight blocks are discarded. Reset asserted mid-burst ends the burst immediately; no partial slices follow after release.
- Constants: WORDS = 64/SLICE_W = 4; FRAME = NUM_SLOTS*WORDS = 16; SLOT_START = OWN_SLOT*WORDS.
- Valid tracking:
  - LATENCY-deep shift register of IN_VALID.
  - IN_VALID=1 in cycle t causes a push of CIPHER_TEXT, sampled in cycle t+LATENCY, at the end of that cycle.
  - FIFO_COUNT reflects the push in cycle t+LATENCY+1.
- Phase counter PH (registered):
  - phase = 0 when SLOT_SYNC=1, else phase = PH.
  - PH_next = (phase+1) mod FRAME; free-running wrap.
- Pop rule:
  - Pop happens in a cycle where phase == SLOT_START, no burst is active, and FIFO_COUNT > 0.
  - The head block loads the shift register, and a burst starts.
- Burst:
  - Registered output. Slices appear in the WORDS cycles after the pop cycle.
  - Slice order: bits [64:64-SLICE_W+1] first, then [64-SLICE_W:64-2*SLICE_W+1], and so on, down to [SLICE_W:1].
  - OUT_VALID=1 for exactly WORDS consecutive cycles. OUT_LAST=1 only with the final slice.
  - A burst is never aborted by SLOT_SYNC; it always completes.
  - Remaining FIFO blocks wait for the next frame's own slot: at most one block per frame.
- FIFO:
  - Push and pop in the same cycle: both are performed, and the count is unchanged.
  - Push while full with no pop: the block is dropped, the FIFO is unchanged, and OVERFLOW is set (sticky until RST).
  - Push while full with a pop in the same cycle: the block is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Empty at slot start: no pop, and OUT_VALID stays 0 for the whole frame.

Decomposition:
- Shared package des_tdm_pkg: BLOCK_W=64, SLICE_W, WORDS, FRAME, and the slot-start function.
- Sub-module des_blk_fifo: synchronous 64-bit FIFO with push, pop, full, empty and count; asynchronous RST.
- Top level: delay line, phase counter, and burst FSM with states IDLE and SEND (beat counter 0..WORDS-1).

Test Plan:
1. Single block, basic timing.
   - Stimulus: RST pulse; SLOT_SYNC every 16 cycles starting at cycle 20; IN_VALID at cycle 2; CIPHER_TEXT=0x85E813540F0AB405 at cycle 18.
   - Required: FIFO_COUNT=1 at cycle 19; OUT_VALID in cycles 21-24 with OUT_DATA 0x85E8, 0x1354, 0x0F0A, 0xB405; OUT_LAST only at cycle 24; FIFO_COUNT=0 from cycle 21.
2. Non-zero slot (OWN_SLOT=2).
   - Stimulus: same stimulus as scenario 1.
   - Required: slices in cycles 29-32 (phase 8 pop at cycle 28); OUT_DATA=0 and OUT_VALID=0 at all other cycles.
3. Back-to-back blocks.
   - Stimulus: IN_VALID at cycles 2 and 3; CIPHER_TEXT=A at cycle 18, B at cycle 19.
   - Required: A bursts in frame 1 (cycles 21-24); B bursts in frame 2 (cycles 37-40); FIFO_COUNT peaks at 2.
4. Overflow.
   - Stimulus: 6 consecutive IN_VALIDs with no SLOT_SYNC and PH held away from SLOT_START.
   - Required: FIFO_COUNT saturates at 4; OVERFLOW=1 from the 5th push onward; first 4 blocks later emitted in order.
5. Simultaneous push and pop.
   - Stimulus: FIFO full; push timed on the pop cycle.
   - Required: block accepted; FIFO_COUNT stays 4; OVERFLOW stays 0.
6. Reset mid-burst.
   - Stimulus: assert RST during the 2nd slice.
   - Required: all outputs 0 in the same cycle; after release, no further slices; FIFO_COUNT=0.

Source files
------------

// File: rtl/des_tdm_pkg.sv
// rtl/des_tdm_pkg.sv - shared constants and slot helper for the DES TDM serializer
package des_tdm_pkg;

    localparam int BLOCK_W   = 64;
    localparam int SLICE_W   = 16;
    localparam int WORDS     = BLOCK_W / SLICE_W;
    localparam int NUM_SLOTS = 4;
    localparam int FRAME     = NUM_SLOTS * WORDS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } burst_state_t;

    // First frame phase belonging to a slot; each slot is one block's worth of beats.
    function automatic int slot_start(input int own_slot, input int words);
        return own_slot * words;
    endfunction

endpackage

// File: rtl/des_blk_fifo.sv
// rtl/des_blk_fifo.sv - captured cipher block FIFO with occupancy count
module des_blk_fifo
    import des_tdm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BLOCK_W-1:0]       push_data,
    input  logic                     pop,
    output logic [BLOCK_W-1:0]       pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_pop;
    logic               do_push;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/des_tdm_cipher_serializer.sv
// rtl/des_tdm_cipher_serializer.sv - captures DES pipeline output and slices it onto an owned TDM slot
module des_tdm_cipher_serializer #(
    parameter int LATENCY    = 16,
    parameter int SLICE_W    = des_tdm_pkg::SLICE_W,
    parameter int NUM_SLOTS  = des_tdm_pkg::NUM_SLOTS,
    parameter int OWN_SLOT   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            IN_VALID,
    input  logic [64:1]                     CIPHER_TEXT,
    input  logic                            SLOT_SYNC,
    output logic [SLICE_W:1]                OUT_DATA,
    output logic                            OUT_VALID,
    output logic                            OUT_LAST,
    output logic [$clog2(FIFO_DEPTH)+1:1]   FIFO_COUNT,
    output logic                            OVERFLOW
);

    import des_tdm_pkg::*;

    localparam int BEATS      = BLOCK_W / SLICE_W;
    localparam int FRAME_LEN  = NUM_SLOTS * BEATS;
    localparam int SLOT_START = slot_start(OWN_SLOT, BEATS);
    localparam int PW         = $clog2(FRAME_LEN);
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [LATENCY-1:0] vld_sr;
    logic [PW-1:0]      ph;
    logic [PW-1:0]      phase;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BLOCK_W-1:0] head;
    logic [BLOCK_W-1:0] shreg;
    logic [BW-1:0]      beat;
    burst_state_t       state;

    // The oldest tap of the delay line lines up with the launch's ciphertext at the pipeline output.
    assign push  = vld_sr[LATENCY-1];
    assign phase = SLOT_SYNC ? '0 : ph;
    assign pop   = (state == IDLE) && (phase == PW'(SLOT_START)) && !fifo_empty;

    des_blk_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (CIPHER_TEXT),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (FIFO_COUNT)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_sr   <= '0;
            ph       <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], IN_VALID};
            ph     <= (phase == PW'(FRAME_LEN-1)) ? '0 : phase + 1'b1;
            if (push && fifo_full && !pop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            beat      <= '0;
            shreg     <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg     <= head << SLICE_W;
                        OUT_DATA  <= head[BLOCK_W-1 -: SLICE_W];
                        OUT_VALID <= 1'b1;
                        OUT_LAST  <= (BEATS == 1);
                        beat      <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (beat == BW'(BEATS-1)) begin
                        OUT_DATA  <= '0;
                        OUT_VALID <= 1'b0;
                        OUT_LAST  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        OUT_DATA  <= shreg[BLOCK_W-1 -: SLICE_W];
                        shreg     <= shreg << SLICE_W;
                        beat      <= beat + 1'b1;
                        OUT_LAST  <= (beat + 1'b1 == BW'(BEATS-1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_tdm_cipher_serializer.sv
// tb/tb_des_tdm_cipher_serializer.sv - scoreboard bench for the DES TDM cipher serializer
module tb_des_tdm_cipher_serializer;

    localparam int LAT   = 16;
    localparam int SW    = 16;
    localparam int NS    = 4;
    localparam int OWN   = 2;
    localparam int DEPTH = 4;
    localparam int WORDS = 64 / SW;
    localparam int FRAME = NS * WORDS;
    localparam int SS    = OWN * WORDS;
    localparam logic [63:0] KAT = 64'h85E813540F0AB405;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          slot_sync = 1'b0;
    logic [64:1]   cipher_text = '0;
    logic [SW:1]   out_data;
    logic          out_valid;
    logic          out_last;
    logic [3:1]    fifo_count;
    logic          overflow;

    des_tdm_cipher_serializer #(
        .LATENCY    (LAT),
        .SLICE_W    (SW),
        .NUM_SLOTS  (NS),
        .OWN_SLOT   (OWN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .IN_VALID    (in_valid),
        .CIPHER_TEXT (cipher_text),
        .SLOT_SYNC   (slot_sync),
        .OUT_DATA    (out_data),
        .OUT_VALID   (out_valid),
        .OUT_LAST    (out_last),
        .FIFO_COUNT  (fifo_count),
        .OVERFLOW    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          at;
        logic [15:0] data;
        logic        last;
        int          idx;
    } slice_t;

    slice_t      exp_q[$];
    logic [63:0] fq[$];
    int          pend[$];
    int          ph_m = 0;
    int          busy_end = -1;
    bit          ovf_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Reference behaviour: one block per frame leaves the queue when the frame reaches our slot.
    task automatic model_step(input bit v, input logic [63:0] d, input bit s);
        int          n;
        int          phase;
        bit          arrive;
        logic [63:0] blk;
        n      = cyc;
        phase  = s ? 0 : ph_m;
        arrive = (pend.size() > 0) && (pend[0] == n);
        if (arrive) void'(pend.pop_front());
        if (v) pend.push_back(n + LAT);
        if (phase == SS && n > busy_end && fq.size() > 0) begin
            blk = fq.pop_front();
            for (int k = 0; k < WORDS; k++)
                exp_q.push_back('{n + 1 + k, blk[63 - SW*k -: SW], k == WORDS - 1, k});
            busy_end = n + WORDS;
        end
        if (arrive) begin
            if (fq.size() < DEPTH) fq.push_back(d);
            else ovf_m = 1'b1;
        end
        ph_m = (phase + 1) % FRAME;
    endtask

    task automatic do_cycle(input bit r, input bit v, input logic [63:0] d, input bit s);
        @(negedge clk);
        #1;
        check("fifo_count", fifo_count, fq.size());
        check("overflow", overflow, ovf_m);
        rst         = r;
        in_valid    = v && !r;
        cipher_text = d;
        slot_sync   = s;
        if (r) begin
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_last", out_last, 0);
            check("rst_fifo_count", fifo_count, 0);
            check("rst_overflow", overflow, 0);
            fq.delete();
            pend.delete();
            exp_q.delete();
            ph_m     = 0;
            busy_end = -1;
            ovf_m    = 1'b0;
        end else begin
            model_step(v && !r, d, s);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                slice_t e;
                e = exp_q.pop_front();
                check("out_valid", out_valid, 1);
                check("out_data", out_data, e.data);
                check("out_last", out_last, e.last);
            end else begin
                check("idle_valid", out_valid, 0);
                check("idle_data", out_data, 0);
                check("idle_last", out_last, 0);
            end
        end
    end

    initial begin
        bit found;
        do_cycle(1, 0, '0, 0);
        do_cycle(1, 0, '0, 0);

        for (int k = 0; k < 72; k++)
            do_cycle(0, k == 2, (k == 18) ? KAT : rnd64(), k == 20 || k == 36 || k == 52);

        for (int k = 0; k < 500; k++)
            do_cycle(0, ($urandom % 5) == 0, rnd64(), ($urandom % 50) == 0);

        for (int k = 0; k < 12; k++)
            do_cycle(0, 1, rnd64(), 0);
        for (int k = 0; k < 110; k++)
            do_cycle(0, 0, rnd64(), 0);

        do_cycle(1, 0, '0, 0);
        for (int k = 0; k < 3; k++)
            do_cycle(0, 1, rnd64(), 0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (exp_q.size() > 0 && exp_q[0].at == cyc + 1 && exp_q[0].idx == 1) found = 1'b1;
            else do_cycle(0, 0, rnd64(), 0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_burst_setup at cycle %0d: got no burst expected burst within 200 cycles", cyc);
        end
        do_cycle(1, 0, '0, 0);
        for (int k = 0; k < 40; k++)
            do_cycle(0, 0, rnd64(), 0);

        for (int k = 0; k < 300; k++)
            do_cycle(0, ($urandom % 3) == 0, rnd64(), ($urandom % 16) == 0);
        for (int k = 0; k < 100; k++)
            do_cycle(0, 0, rnd64(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
